// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : pipe_pkg
// Field widths, func codes and the packed instruction word for the issue path.
// Revision: 1.0
// ============================================================================
package pipe_pkg;

  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;
  localparam int FUNC_W = 4;

  typedef enum logic [FUNC_W-1:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_MUL  = 4'd2,
    FN_SELA = 4'd3,
    FN_SELB = 4'd4,
    FN_AND  = 4'd5,
    FN_OR   = 4'd6,
    FN_XOR  = 4'd7,
    FN_NEGA = 4'd8,
    FN_NEGB = 4'd9,
    FN_SRA  = 4'd10,
    FN_SLA  = 4'd11
  } func_e;

  localparam logic [FUNC_W-1:0] FN_MAX = 4'd11;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic logic func_valid(input logic [FUNC_W-1:0] f);
    return (f <= FN_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : pipe_issue_ctrl_if
// Instruction source / issue port bundle of the issue controller.
// Revision: 1.0
// ============================================================================
interface pipe_issue_ctrl_if #(
  parameter int NREG = 16
);
  import pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [REG_W-1:0]  in_rd;
  logic [FUNC_W-1:0] in_func;
  logic [ADDR_W-1:0] in_addr;
  logic              flush;
  logic              iss_valid;
  logic [REG_W-1:0]  iss_rs1;
  logic [REG_W-1:0]  iss_rs2;
  logic [REG_W-1:0]  iss_rd;
  logic [FUNC_W-1:0] iss_func;
  logic [ADDR_W-1:0] iss_addr;
  logic [NREG-1:0]   busy_mask;
  logic              bad_func;
  logic [15:0]       issue_count;
  logic [15:0]       stall_count;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, flush,
    input  in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr,
    input  busy_mask, bad_func, issue_count, stall_count
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, flush,
    output in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr,
    output busy_mask, bad_func, issue_count, stall_count
  );

endinterface
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// ============================================================================
// Module : issue_fifo
// Synchronous FIFO of packed instruction words with count and flush.
// Revision: 1.0
// ============================================================================
module issue_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         flush,
  input  wire logic                         wr_en,
  input  wire instr_t                       wr_data,
  input  wire logic                         rd_en,
  output instr_t                            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full,
  output logic                              empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [PW-1:0] c_ptr_one = PW'(1);

  instr_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_wr;
  logic            w_rd;

  assign full    = (r_count == c_depth);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rptr];

  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= wr_data;
        r_wptr        <= r_wptr + c_ptr_one;
      end
      if (w_rd) r_rptr <= r_rptr + c_ptr_one;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_issue_ctrl
// In-order issue controller with a fixed-latency write-back scoreboard.
// Revision: 1.0
// ============================================================================
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 3,
  parameter int NREG   = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pipe_issue_ctrl_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
  localparam logic [15:0]   c_cnt_max = 16'hFFFF;

  instr_t                         w_in;
  instr_t                         w_head;
  logic [CW-1:0]                  w_count;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_func_ok;
  logic                           w_hazard;
  logic                           w_issue;
  logic                           w_drop;
  logic                           w_stall;
  logic [NREG-1:0]                w_busy;
  logic [NREG-1:0]                w_block;

  logic [WB_LAT-1:0]              r_pend_v;
  logic [WB_LAT-1:0][REG_W-1:0]   r_pend_rd;
  logic                           r_iss_valid;
  instr_t                         r_iss;
  logic                           r_bad;
  logic [15:0]                    r_issue_cnt;
  logic [15:0]                    r_stall_cnt;

  assign w_in = {bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_func, bus.in_addr};

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.flush),
    .wr_en   (w_push),
    .wr_data (w_in),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign bus.in_ready = (w_count < c_depth);
  assign w_push       = bus.in_valid && !w_full && !bus.flush;

  // The last stage retires on the edge a dependent may issue, so it is
  // reported in busy_mask but does not block the issue decision.
  always_comb begin
    w_busy  = '0;
    w_block = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (r_pend_v[i]) begin
        w_busy[r_pend_rd[i]] = 1'b1;
        if (i < WB_LAT - 1) w_block[r_pend_rd[i]] = 1'b1;
      end
    end
  end

  assign w_func_ok = func_valid(w_head.func);
  assign w_hazard  = w_block[w_head.rs1] | w_block[w_head.rs2];
  assign w_issue   = !bus.flush && !w_empty && w_func_ok && !w_hazard;
  assign w_drop    = !bus.flush && !w_empty && !w_func_ok;
  assign w_stall   = !bus.flush && !w_empty && w_func_ok && w_hazard;
  assign w_pop     = w_issue || w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v  <= '0;
      r_pend_rd <= '0;
    end else if (bus.flush) begin
      r_pend_v  <= '0;
    end else begin
      r_pend_v  <= {r_pend_v[WB_LAT-2:0], w_issue};
      r_pend_rd <= {r_pend_rd[WB_LAT-2:0], w_head.rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss       <= '0;
      r_bad       <= 1'b0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_iss_valid <= w_issue;
      r_bad       <= w_drop;
      if (w_issue) r_iss <= w_head;
      if (w_issue && (r_issue_cnt != c_cnt_max)) r_issue_cnt <= r_issue_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.iss_valid   = r_iss_valid;
  assign bus.iss_rs1     = r_iss.rs1;
  assign bus.iss_rs2     = r_iss.rs2;
  assign bus.iss_rd      = r_iss.rd;
  assign bus.iss_func    = r_iss.func;
  assign bus.iss_addr    = r_iss.addr;
  assign bus.busy_mask   = w_busy;
  assign bus.bad_func    = r_bad;
  assign bus.issue_count = r_issue_cnt;
  assign bus.stall_count = r_stall_cnt;

endmodule
`default_nettype wire
